line_buffer_fill_ctrl: RTL and testbench

LINE_BUFFER_FILL_CTRL -- requirements
Module: line_buffer_fill_ctrl

---
 rtl/line_buffer_fill_ctrl_pkg.sv | 20 ++
 rtl/line_buffer_fill_ctrl.sv | 122 ++++++++++++
 tb/tb_line_buffer_fill_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_buffer_fill_ctrl_pkg.sv
// Shared definitions for the line buffer fill controller: FSM state encoding
// and the line-stride / RAM geometry constants.
package line_buffer_fill_ctrl_pkg;

    // Fill sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } fillState_t;

    // Each line occupies 512 bytes of source memory
    localparam int LINE_SHIFT = 9;

    // 128 x 64 line RAM split into two 64-word banks
    localparam int RAM_ADDR_W  = 7;
    localparam int BANK_ADDR_W = 6;

endpackage

// File: rtl/line_buffer_fill_ctrl.sv
// Double-buffered line RAM fill controller. Fetches one burst of 64-bit
// words per line into the back bank while the front bank is displayed,
// and flips banks on a line-boundary swap strobe once the back bank is full.
module line_buffer_fill_ctrl
    import line_buffer_fill_ctrl_pkg::*;
#(
    parameter int BURST_LEN      = 64,
    parameter int ROM_ADDR_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      io_start,
    input  logic [8:0]                io_line,
    input  logic [ROM_ADDR_WIDTH-1:0] io_baseAddr,
    input  logic                      io_swap,
    output logic                      io_busy,
    output logic                      io_ready,
    output logic                      io_bank,
    output logic                      io_underrun,
    output logic                      io_rom_rd,
    output logic [ROM_ADDR_WIDTH-1:0] io_rom_addr,
    input  logic                      io_rom_waitReq,
    input  logic                      io_rom_valid,
    input  logic [63:0]               io_rom_dout,
    output logic                      io_ram_wr,
    output logic [RAM_ADDR_W-1:0]     io_ram_addr,
    output logic [63:0]               io_ram_din
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    fillState_t                stateReg;
    fillState_t                stateNext;
    logic [CNT_W-1:0]          cntReg;
    logic [ROM_ADDR_WIDTH-1:0] romAddrReg;
    logic                      bankReg;
    logic                      readyReg;
    logic                      underrunReg;

    logic                      startAccept;
    logic                      beatAccept;
    logic                      lastBeat;
    logic [BANK_ADDR_W-1:0]    beatAddr;

    assign startAccept = (stateReg == IDLE) && io_start;
    assign beatAccept  = (stateReg == DATA) && io_rom_valid;
    assign lastBeat    = beatAccept && (cntReg == CNT_W'(BURST_LEN - 1));
    assign beatAddr    = BANK_ADDR_W'(cntReg);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic: request held until the memory stops stalling,
    // then count beats until the burst is complete
    always_comb begin
        stateNext = stateReg;
        unique case (stateReg)
            IDLE: if (io_start)        stateNext = REQ;
            REQ:  if (!io_rom_waitReq) stateNext = DATA;
            DATA: if (lastBeat)        stateNext = DONE;
            DONE:                      stateNext = IDLE;
            default:                   stateNext = IDLE;
        endcase
    end

    // Output decode; RAM writes are combinational pass-through of beats
    always_comb begin
        io_busy     = (stateReg != IDLE);
        io_rom_rd   = (stateReg == REQ);
        io_rom_addr = romAddrReg;
        io_ram_wr   = beatAccept;
        io_ram_addr = {~bankReg, beatAddr};
        io_ram_din  = io_rom_dout;
        io_ready    = readyReg;
        io_bank     = bankReg;
        io_underrun = underrunReg;
    end

    // Datapath state: beat counter, captured address, bank/ready/underrun flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cntReg      <= '0;
            romAddrReg  <= '0;
            bankReg     <= 1'b0;
            readyReg    <= 1'b0;
            underrunReg <= 1'b0;
        end else begin
            if (startAccept) begin
                cntReg     <= '0;
                romAddrReg <= io_baseAddr
                            + (ROM_ADDR_WIDTH'(io_line) << LINE_SHIFT);
            end else if (beatAccept) begin
                cntReg <= cntReg + 1'b1;
            end

            // The back bank becomes valid at the end of DONE; a swap seen in
            // the same cycle still uses the old (low) ready and underruns.
            if (stateReg == DONE) begin
                readyReg <= 1'b1;
            end else if (io_swap && readyReg) begin
                readyReg <= 1'b0;
                bankReg  <= ~bankReg;
            end else if (startAccept) begin
                readyReg <= 1'b0;
            end

            // Sticky until the next accepted start; a simultaneous late swap wins
            if (io_swap && !readyReg) begin
                underrunReg <= 1'b1;
            end else if (startAccept) begin
                underrunReg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_fill_ctrl.sv
// Self-checking bench for line_buffer_fill_ctrl: a table of fill scenarios
// plus hand-written sequences for underrun, ignored start and mid-burst reset.
// RAM writes are checked against a scoreboard queue filled as beats are driven.
module tb_line_buffer_fill_ctrl;

    localparam int BURST = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_start = 1'b0;
    logic [8:0]  io_line = '0;
    logic [31:0] io_baseAddr = '0;
    logic        io_swap = 1'b0;
    logic        io_busy;
    logic        io_ready;
    logic        io_bank;
    logic        io_underrun;
    logic        io_rom_rd;
    logic [31:0] io_rom_addr;
    logic        io_rom_waitReq = 1'b0;
    logic        io_rom_valid = 1'b0;
    logic [63:0] io_rom_dout = '0;
    logic        io_ram_wr;
    logic [6:0]  io_ram_addr;
    logic [63:0] io_ram_din;

    line_buffer_fill_ctrl #(.BURST_LEN(BURST), .ROM_ADDR_WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .io_start       (io_start),
        .io_line        (io_line),
        .io_baseAddr    (io_baseAddr),
        .io_swap        (io_swap),
        .io_busy        (io_busy),
        .io_ready       (io_ready),
        .io_bank        (io_bank),
        .io_underrun    (io_underrun),
        .io_rom_rd      (io_rom_rd),
        .io_rom_addr    (io_rom_addr),
        .io_rom_waitReq (io_rom_waitReq),
        .io_rom_valid   (io_rom_valid),
        .io_rom_dout    (io_rom_dout),
        .io_ram_wr      (io_ram_wr),
        .io_ram_addr    (io_ram_addr),
        .io_ram_din     (io_ram_din)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [6:0]  addr;
        logic [63:0] data;
    } wrExp_t;

    typedef struct {
        logic [8:0]  line;
        logic [31:0] base;
        int          waitCycles;
        int          gap;
        bit          extraBeat;
        logic [31:0] expAddr;
    } fillVec_t;

    wrExp_t   sbq[$];
    fillVec_t vecs[4];
    int       total = 0;
    int       bad = 0;
    logic     expBank = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one valid beat and record the write it must produce
    task automatic driveBeat(input int idx);
        wrExp_t e;
        io_rom_valid = 1'b1;
        io_rom_dout  = {$urandom, $urandom};
        e.addr = {~expBank, 6'(idx)};
        e.data = io_rom_dout;
        sbq.push_back(e);
    endtask

    // Scoreboard: every RAM write must match the oldest expected beat
    always @(negedge clock) begin
        if (io_ram_wr) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr 0x%0h required no write at %0t",
                         io_ram_addr, $time);
            end else begin
                wrExp_t e;
                e = sbq.pop_front();
                chk("ram_addr", 64'(io_ram_addr), 64'(e.addr));
                chk("ram_din", io_ram_din, e.data);
            end
        end
    end

    task automatic runFill(input fillVec_t v, input int idx);
        tick();
        io_start    = 1'b1;
        io_line     = v.line;
        io_baseAddr = v.base;
        #1;
        chk("idle_busy", 64'(io_busy), 64'd0);
        tick();
        io_start = 1'b0;
        for (int i = 0; i <= v.waitCycles; i++) begin
            io_rom_waitReq = (i < v.waitCycles);
            #1;
            chk("req_rd", 64'(io_rom_rd), 64'd1);
            chk("req_addr", 64'(io_rom_addr), 64'(v.expAddr));
            chk("req_ready", 64'(io_ready), 64'd0);
            tick();
        end
        io_rom_waitReq = 1'b0;
        for (int b = 0; b < BURST; b++) begin
            for (int g = 1; g < v.gap; g++) begin
                io_rom_valid = 1'b0;
                #1;
                chk("gap_nowr", 64'(io_ram_wr), 64'd0);
                tick();
            end
            driveBeat(b);
            #1;
            chk("data_rd", 64'(io_rom_rd), 64'd0);
            chk("data_busy", 64'(io_busy), 64'd1);
            tick();
        end
        // DONE cycle: optional stray beat must not be written
        io_rom_valid = v.extraBeat;
        io_rom_dout  = {$urandom, $urandom};
        #1;
        chk("done_busy", 64'(io_busy), 64'd1);
        chk("done_ready", 64'(io_ready), 64'd0);
        tick();
        io_rom_valid = 1'b0;
        #1;
        chk("after_done_ready", 64'(io_ready), 64'd1);
        chk("after_done_busy", 64'(io_busy), 64'd0);
        chk("after_done_bank", 64'(io_bank), 64'(expBank));
        chk("fill_sb_empty", 64'(sbq.size()), 64'd0);
        $display("fill %0d: line=%0d base=0x%08h addr=0x%08h bank=%0d", idx, v.line,
                 v.base, io_rom_addr, io_bank);
    endtask

    task automatic swapReady();
        io_swap = 1'b1;
        tick();
        io_swap = 1'b0;
        expBank = ~expBank;
        #1;
        chk("swap_bank", 64'(io_bank), 64'(expBank));
        chk("swap_ready", 64'(io_ready), 64'd0);
        $display("swap: bank=%0d", io_bank);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{line: 9'd3,   base: 32'h0010_0000, waitCycles: 0, gap: 1, extraBeat: 1'b0, expAddr: 32'h0010_0600};
        vecs[1] = '{line: 9'd7,   base: 32'h2000_0000, waitCycles: 5, gap: 1, extraBeat: 1'b0, expAddr: 32'h2000_0E00};
        vecs[2] = '{line: 9'd100, base: 32'h0000_0000, waitCycles: 0, gap: 3, extraBeat: 1'b1, expAddr: 32'h0000_C800};
        vecs[3] = '{line: 9'd511, base: 32'hFFFF_FF00, waitCycles: 2, gap: 2, extraBeat: 1'b1, expAddr: 32'h0003_FD00};

        // Reset state
        #12;
        chk("rst_busy", 64'(io_busy), 64'd0);
        chk("rst_ready", 64'(io_ready), 64'd0);
        chk("rst_bank", 64'(io_bank), 64'd0);
        chk("rst_underrun", 64'(io_underrun), 64'd0);
        chk("rst_rd", 64'(io_rom_rd), 64'd0);
        chk("rst_wr", 64'(io_ram_wr), 64'd0);
        tick();
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            runFill(vecs[i], i);
            tick();
            swapReady();
        end

        // Ignored start during REQ, swap underrun during DATA and at DONE
        tick();
        io_start    = 1'b1;
        io_line     = 9'd1;
        io_baseAddr = 32'h0000_1000;
        tick();
        io_start       = 1'b0;
        io_rom_waitReq = 1'b1;
        io_start       = 1'b1;
        io_line        = 9'd9;
        io_baseAddr    = 32'hDEAD_0000;
        #1;
        chk("req_addr_a", 64'(io_rom_addr), 64'h1200);
        tick();
        io_start       = 1'b0;
        io_rom_waitReq = 1'b0;
        #1;
        chk("busy_start_ignored", 64'(io_rom_addr), 64'h1200);
        chk("busy_start_rd", 64'(io_rom_rd), 64'd1);
        tick();
        for (int b = 0; b < BURST; b++) begin
            io_swap = (b == 10);
            driveBeat(b);
            #1;
            if (b == 11) begin
                chk("underrun_set", 64'(io_underrun), 64'd1);
                chk("underrun_bank", 64'(io_bank), 64'(expBank));
            end
            tick();
        end
        io_rom_valid = 1'b0;
        io_swap      = 1'b1;
        #1;
        chk("done_swap_ready", 64'(io_ready), 64'd0);
        tick();
        io_swap = 1'b0;
        #1;
        chk("done_swap_ready_set", 64'(io_ready), 64'd1);
        chk("done_swap_underrun", 64'(io_underrun), 64'd1);
        chk("done_swap_bank", 64'(io_bank), 64'(expBank));
        chk("seqA_sb_empty", 64'(sbq.size()), 64'd0);
        $display("seq underrun: bank=%0d underrun=%0d", io_bank, io_underrun);
        swapReady();
        chk("underrun_sticky", 64'(io_underrun), 64'd1);

        // Accepted start clears underrun; reset at beat 20 abandons the fill
        io_start    = 1'b1;
        io_line     = 9'd2;
        io_baseAddr = 32'h0;
        tick();
        io_start = 1'b0;
        #1;
        chk("start_clr_underrun", 64'(io_underrun), 64'd0);
        chk("start_clr_ready", 64'(io_ready), 64'd0);
        chk("start_busy", 64'(io_busy), 64'd1);
        tick();
        for (int b = 0; b < 20; b++) begin
            driveBeat(b);
            tick();
        end
        io_rom_valid = 1'b1;
        reset        = 1'b1;
        #1;
        expBank = 1'b0;
        chk("midrst_rd", 64'(io_rom_rd), 64'd0);
        chk("midrst_wr", 64'(io_ram_wr), 64'd0);
        chk("midrst_busy", 64'(io_busy), 64'd0);
        chk("midrst_bank", 64'(io_bank), 64'd0);
        chk("midrst_ready", 64'(io_ready), 64'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("postrst_nowr", 64'(io_ram_wr), 64'd0);
            tick();
        end
        io_rom_valid = 1'b0;
        chk("seqB_sb_empty", 64'(sbq.size()), 64'd0);
        $display("seq reset: busy=%0d bank=%0d", io_busy, io_bank);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
